// File: rtl/subtractor.sv
// ---------------------------------------------------------------------------
// subtractor
//
// Multi-cycle two's-complement subtractor: out = in1 - in2 (mod 2^WIDTH).
// The difference is formed by repeated XOR / borrow-shift, resolving one
// borrow-propagation step per clock. This is the inverse-direction companion
// of the ALU's iterative carry-propagation adder.
//
// Ports
//   CK      in   1      clock, rising-edge active
//   RST     in   1      synchronous active-high reset (priority over start)
//   start   in   1      request, sampled only while idle (busy = 0)
//   in1     in   WIDTH  minuend, captured on the accepted start edge
//   in2     in   WIDTH  subtrahend, captured on the accepted start edge
//   out     out  WIDTH  difference, updated only on the done edge
//   busy    out  1      high from accepted start until the done edge
//   done    out  1      one-cycle completion pulse
//   borrow  out  1      unsigned borrow-out (in1 < in2 unsigned)
//   zero    out  1      out == 0
//   neg     out  1      out[WIDTH-1]
//   ovf     out  1      signed overflow of the subtraction
//
// Latency is k+1 cycles from the accepted start edge, where k (0..WIDTH-1)
// is the number of borrow-propagation iterations needed.
// ---------------------------------------------------------------------------
module subtractor #(
  parameter int WIDTH = 16
) (
  input  logic             CK,
  input  logic             RST,
  input  logic             start,
  input  logic [WIDTH-1:0] in1,
  input  logic [WIDTH-1:0] in2,
  output logic [WIDTH-1:0] out,
  output logic             busy,
  output logic             done,
  output logic             borrow,
  output logic             zero,
  output logic             neg,
  output logic             ovf
);

  typedef enum logic {
    IDLE = 1'b0,
    RUN  = 1'b1
  } state_t;

  state_t           state_reg;
  logic [WIDTH-1:0] diff_reg;    // partial difference
  logic [WIDTH-1:0] b_reg;       // borrows still waiting to be applied
  logic             bacc_reg;    // any borrow that fell off the MSB
  logic             a_msb_reg;   // captured sign of the minuend
  logic             b_msb_reg;   // captured sign of the subtrahend

  // Per-bit borrow generate terms. A borrow is produced at bit i wherever
  // the minuend bit is 0 and the bit being subtracted is 1; it then moves
  // one position up on the next step.
  logic [WIDTH-1:0] t_start;     // from the raw operands, used at accept
  logic [WIDTH-1:0] t_run;       // from the partial difference, used in RUN

  generate
    for (genvar gi = 0; gi < WIDTH; gi++) begin : g_borrow
      assign t_start[gi] = ~in1[gi] & in2[gi];
      assign t_run[gi]   = ~diff_reg[gi] & b_reg[gi];
    end
  endgenerate

  always_ff @(posedge CK) begin
    if (RST) begin
      state_reg <= IDLE;
      diff_reg  <= '0;
      b_reg     <= '0;
      bacc_reg  <= 1'b0;
      a_msb_reg <= 1'b0;
      b_msb_reg <= 1'b0;
      out       <= '0;
      busy      <= 1'b0;
      done      <= 1'b0;
      borrow    <= 1'b0;
      zero      <= 1'b0;
      neg       <= 1'b0;
      ovf       <= 1'b0;
    end else begin
      case (state_reg)
        IDLE: begin
          // Clearing done here also covers the back-to-back case, where a
          // new start is accepted on the edge right after the done pulse.
          done <= 1'b0;
          if (start) begin
            diff_reg  <= in1 ^ in2;
            b_reg     <= t_start << 1;
            bacc_reg  <= t_start[WIDTH-1];
            a_msb_reg <= in1[WIDTH-1];
            b_msb_reg <= in2[WIDTH-1];
            busy      <= 1'b1;
            state_reg <= RUN;
          end
        end

        RUN: begin
          if (b_reg != '0) begin
            // Apply pending borrows; the ones that ripple past the MSB are
            // dropped from b_reg and remembered only in bacc_reg.
            diff_reg <= diff_reg ^ b_reg;
            b_reg    <= t_run << 1;
            bacc_reg <= bacc_reg | t_run[WIDTH-1];
          end else begin
            out       <= diff_reg;
            borrow    <= bacc_reg;
            zero      <= (diff_reg == '0);
            neg       <= diff_reg[WIDTH-1];
            // Overflow only possible when the operand signs differ, and
            // shows up as a result whose sign disagrees with the minuend.
            ovf       <= (a_msb_reg != b_msb_reg) &&
                         (diff_reg[WIDTH-1] != a_msb_reg);
            done      <= 1'b1;
            busy      <= 1'b0;
            state_reg <= IDLE;
          end
        end
      endcase
    end
  end

endmodule
